// File: rtl/i2c_arb_pkg.sv
// Shared types and sizing helpers for the I2C requester arbiter.
// Purely declarative: no latency, no backpressure.
// Consumers import with i2c_arb_pkg::*.
package i2c_arb_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_START,
        ACTIVE,
        COMPLETE
    } arb_state_t;

    // Ceiling log2 with a floor of 1 so single-value counters still get a bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/i2c_rr_pick.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; found=0 when no request is set.
module i2c_rr_pick
    import i2c_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  onehot,
    output logic [PTR_W-1:0] index,
    output logic             found
);

    always_comb begin
        int idx;
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        idx    = 0;
        // Walk from farthest to nearest so the nearest set bit is written last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                onehot      = '0;
                onehot[idx] = 1'b1;
                index       = PTR_W'(idx);
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin share of one i2c master; completion inferred from sclk idle time.
// Latency: grant + m_trigger one edge after a request is seen in IDLE; one idle cycle between transfers.
// Backpressure: requesters hold req until their done pulse; a watchdog bounds every transfer.
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int TIMEOUT     = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [ADDR_W*NREQ-1:0] req_addr,
    input  logic [NREQ-1:0]        req_rw,
    input  logic [DATA_W*NREQ-1:0] req_din,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        done,
    output logic                   err,
    output logic [DATA_W-1:0]      rdata,
    output logic                   m_trigger,
    output logic [ADDR_W-1:0]      m_address,
    output logic                   m_rw,
    output logic [DATA_W-1:0]      m_din,
    input  logic [DATA_W-1:0]      m_dout,
    input  logic                   m_sclk
);

    localparam int PTR_W = clog2(NREQ);
    localparam int HI_W  = clog2(IDLE_CYCLES);
    localparam int WD_W  = clog2(TIMEOUT);

    arb_state_t        state, state_nxt;
    logic [PTR_W-1:0]  ptr, owner;
    logic [NREQ-1:0]   grant_q;
    logic [HI_W-1:0]   hi_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic              sclk_q, err_q;
    logic [NREQ-1:0]   pick_onehot;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_found;
    logic              sclk_fall, idle_hit, wd_hit;

    i2c_rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .index  (pick_idx),
        .found  (pick_found)
    );

    assign sclk_fall = sclk_q & ~m_sclk;
    assign idle_hit  = m_sclk && (hi_cnt == HI_W'(IDLE_CYCLES - 1));
    // Watchdog lands on TIMEOUT-1 at this edge, so done is TIMEOUT cycles after the trigger.
    assign wd_hit    = (wd_cnt == WD_W'(TIMEOUT - 2));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (pick_found) state_nxt = LAUNCH;
            LAUNCH:     state_nxt = WAIT_START;
            WAIT_START: begin
                if (wd_hit)         state_nxt = COMPLETE;
                else if (sclk_fall) state_nxt = ACTIVE;
            end
            ACTIVE:     if (wd_hit || idle_hit) state_nxt = COMPLETE;
            COMPLETE:   state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_trigger = (state == LAUNCH);
        done      = (state == COMPLETE) ? grant_q : '0;
        err       = (state == COMPLETE) && err_q;
    end

    assign grant = grant_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            owner     <= '0;
            grant_q   <= '0;
            hi_cnt    <= '0;
            wd_cnt    <= '0;
            sclk_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata     <= '0;
            m_address <= '0;
            m_rw      <= 1'b0;
            m_din     <= '0;
        end else begin
            sclk_q <= m_sclk;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner     <= pick_idx;
                        grant_q   <= pick_onehot;
                        m_address <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                        m_rw      <= req_rw[pick_idx];
                        m_din     <= req_din[pick_idx*DATA_W +: DATA_W];
                    end
                end
                LAUNCH: begin
                    wd_cnt <= '0;
                    hi_cnt <= '0;
                end
                WAIT_START, ACTIVE: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    hi_cnt <= (state == ACTIVE && m_sclk) ? hi_cnt + 1'b1 : '0;
                end
                COMPLETE: begin
                    grant_q <= '0;
                    ptr     <= (owner == PTR_W'(NREQ - 1)) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
            // Capture on entry so rdata/err are already valid during the done cycle.
            if (state != COMPLETE && state_nxt == COMPLETE) begin
                rdata <= m_dout;
                err_q <= wd_hit;
            end
        end
    end

endmodule
